gray_code_counter: RTL and testbench

//   Synchronous up/down counter that emits a registered Gray-code count.

---
 rtl/gray_code_counter.sv | 76 +++++++
 tb/tb_gray_code_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - loadable up/down counter with registered Gray-code output
// Optional feature macro: GRAY_CNT_BIN_OUT_EN (adds bin_out, the registered binary count)
module gray_code_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic             tc
`ifdef GRAY_CNT_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] bin_out
`endif
);

  localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] BIN_MIN = {WIDTH{1'b0}};

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nxt;
  logic             tc_nxt;
  logic             at_top;
  logic             at_bottom;

  assign at_top    = (bin == BIN_MAX);
  assign at_bottom = (bin == BIN_MIN);

  // Next-state binary count and terminal-count flag; load outranks en, en outranks hold.
  always_comb begin
    bin_nxt = bin;
    tc_nxt  = 1'b0;
    if (load) begin
      bin_nxt = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
          // Boundary step: flag it whether we wrap or saturate.
          tc_nxt  = 1'b1;
          bin_nxt = WRAP ? BIN_MIN : bin;
        end else begin
          bin_nxt = bin + 1'b1;
        end
      end else begin
        if (at_bottom) begin
          tc_nxt  = 1'b1;
          bin_nxt = WRAP ? BIN_MAX : bin;
        end else begin
          bin_nxt = bin - 1'b1;
        end
      end
    end
  end

  // State and outputs; gray is encoded from bin_nxt so it is a clean flop output aligned with bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
      tc   <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      gray <= bin_nxt ^ (bin_nxt >> 1);
      tc   <= tc_nxt;
    end
  end

`ifdef GRAY_CNT_BIN_OUT_EN
  assign bin_out = bin;
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// tb/tb_gray_code_counter.sv - directed self-checking bench for gray_code_counter (wrap and saturate instances)
module tb_gray_code_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] gray_w;
  logic       tc_w;
  logic [3:0] gray_s;
  logic       tc_s;
`ifdef GRAY_CNT_BIN_OUT_EN
  logic [3:0] bin_w;
  logic [3:0] bin_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gray_code_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .gray     (gray_w),
    .tc       (tc_w)
`ifdef GRAY_CNT_BIN_OUT_EN
    ,
    .bin_out  (bin_w)
`endif
  );

  gray_code_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .gray     (gray_s),
    .tc       (tc_s)
`ifdef GRAY_CNT_BIN_OUT_EN
    ,
    .bin_out  (bin_s)
`endif
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [3:0] up_seq [16];
  logic [3:0] prev;

  initial begin
    up_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'h0;
    repeat (2) tick();
    check("reset_gray", {28'd0, gray_w}, 32'h0);
    check("reset_tc", {31'd0, tc_w}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Advance to a nonzero count so the asynchronous reset has something to clear.
    en = 1'b1; up_dn = 1'b1;
    repeat (3) tick();
    check("precount_gray", {28'd0, gray_w}, 32'h2);

    // Mid-cycle asynchronous reset, no clock edge in between.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_gray", {28'd0, gray_w}, 32'h0);
    check("async_rst_tc", {31'd0, tc_w}, 32'h0);
    check("async_rst_sat_gray", {28'd0, gray_s}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_hold%0d_gray", i), {28'd0, gray_w}, 32'h0);
      check($sformatf("rst_hold%0d_tc", i), {31'd0, tc_w}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; up_dn = 1'b1;

    // Count up through a full wrap.
    prev = 4'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("up%0d_gray", i), {28'd0, gray_w}, {28'd0, up_seq[i]});
      check($sformatf("up%0d_tc", i), {31'd0, tc_w}, {31'd0, (i == 15)});
      check($sformatf("up%0d_onebit", i), $countones(gray_w ^ prev), 32'd1);
`ifdef GRAY_CNT_BIN_OUT_EN
      check($sformatf("up%0d_bin", i), {28'd0, bin_w}, (i + 1) % 16);
      check($sformatf("up%0d_bin_g2b", i), {28'd0, bin_w}, {28'd0, g2b(gray_w)});
`endif
      prev = gray_w;
      if (i == 14) begin
        check("sat_reach_top_gray", {28'd0, gray_s}, 32'h8);
        check("sat_reach_top_tc", {31'd0, tc_s}, 32'h0);
      end
    end
    check("sat_held_top_gray", {28'd0, gray_s}, 32'h8);
    check("sat_held_top_tc", {31'd0, tc_s}, 32'h1);

    // Count down from 0: wrap to 15.
    up_dn = 1'b0;
    tick();
    check("down_wrap_gray", {28'd0, gray_w}, 32'h8);
    check("down_wrap_tc", {31'd0, tc_w}, 32'h1);
    check("sat_down_gray", {28'd0, gray_s}, 32'h9);
    check("sat_down_tc", {31'd0, tc_s}, 32'h0);
    tick();
    check("down_next_gray", {28'd0, gray_w}, 32'h9);
    check("down_next_tc", {31'd0, tc_w}, 32'h0);

    // Hold with en low.
    en = 1'b0;
    tick();
    check("hold_gray", {28'd0, gray_w}, 32'h9);
    check("hold_tc", {31'd0, tc_w}, 32'h0);

    // Load beats en on the same edge.
    load = 1'b1; load_val = 4'h9; en = 1'b1; up_dn = 1'b1;
    tick();
    check("load_gray", {28'd0, gray_w}, 32'hD);
    check("load_tc", {31'd0, tc_w}, 32'h0);
    check("load_sat_gray", {28'd0, gray_s}, 32'hD);
    load = 1'b0;
    tick();
    check("load_up_gray", {28'd0, gray_w}, 32'hF);

    // Saturate at the top.
    load = 1'b1; load_val = 4'hF;
    tick();
    check("sat_load_gray", {28'd0, gray_s}, 32'h8);
    check("sat_load_tc", {31'd0, tc_s}, 32'h0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_up%0d_gray", i), {28'd0, gray_s}, 32'h8);
      check($sformatf("sat_up%0d_tc", i), {31'd0, tc_s}, 32'h1);
      if (i == 0) begin
        check("wrap_top_gray", {28'd0, gray_w}, 32'h0);
        check("wrap_top_tc", {31'd0, tc_w}, 32'h1);
      end
    end
    up_dn = 1'b0;
    tick();
    check("sat_leave_gray", {28'd0, gray_s}, 32'h9);
    check("sat_leave_tc", {31'd0, tc_s}, 32'h0);

    // Saturate at the bottom.
    load = 1'b1; load_val = 4'h0;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    check("sat_bottom_gray", {28'd0, gray_s}, 32'h0);
    check("sat_bottom_tc", {31'd0, tc_s}, 32'h1);
    check("wrap_bottom_gray", {28'd0, gray_w}, 32'h8);
    check("wrap_bottom_tc", {31'd0, tc_w}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
